// File: rtl/lab3_logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with eight ops, a per-beat PAIR mode and a
// burst-reducing ACCUM mode, valid/ready on both sides and one output register.
module lab3_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             F_red,
    output logic [CNT_W-1:0] beats
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, acc_upd;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_upd;
    logic [2:0]       op_q, op_nxt;
    logic             accept, load;
    logic [WIDTH-1:0] f_nxt;
    logic [CNT_W-1:0] beats_nxt;

    function automatic logic [WIDTH-1:0] pair_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (o)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return ~(a ^ b);
            3'b110:  return ~a;
            default: return a;
        endcase
    endfunction

    // Inverting ops reduce with their non-inverted base and invert once at the end.
    function automatic logic [WIDTH-1:0] base_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] a);
        case (o)
            3'b000, 3'b011: return x & a;
            3'b001, 3'b100: return x | a;
            3'b010, 3'b101: return x ^ a;
            default:        return a;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] fin_op(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x);
        case (o)
            3'b011, 3'b100, 3'b101, 3'b110: return ~x;
            default:                        return x;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign acc_upd  = base_op(op_q, acc, A);
    assign cnt_upd  = sat_inc(cnt);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        load      = 1'b0;
        f_nxt     = F;
        beats_nxt = beats;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!mode) begin
                        load      = 1'b1;
                        f_nxt     = pair_op(op, A, B);
                        beats_nxt = CNT_W'(1);
                    end else if (!last) begin
                        op_nxt    = op;
                        acc_nxt   = A;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ACC;
                    end else begin
                        load      = 1'b1;
                        f_nxt     = fin_op(op, A);
                        beats_nxt = CNT_W'(1);
                    end
                end
                default: begin
                    acc_nxt = acc_upd;
                    cnt_nxt = cnt_upd;
                    if (last) begin
                        load      = 1'b1;
                        f_nxt     = fin_op(op_q, acc_upd);
                        beats_nxt = cnt_upd;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Control/burst state and the single output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= '0;
            out_valid <= 1'b0;
            F         <= '0;
            F_red     <= 1'b0;
            beats     <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            if (load) begin
                out_valid <= 1'b1;
                F         <= f_nxt;
                F_red     <= |f_nxt;
                beats     <= beats_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lab3_logic_unit.sv
// Scoreboard bench for lab3_logic_unit: expectations queued at accept, compared on output handshake.
module tb_lab3_logic_unit;

    typedef struct packed {
        logic [7:0] f;
        logic [3:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, mode, last, out_valid, out_ready, F_red;
    logic [7:0] A, B, F;
    logic [2:0] op;
    logic [3:0] beats;
    logic       in_valid2, in_ready2, out_valid2, F_red2;
    logic [7:0] F2;
    logic [1:0] beats2;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    exp_t sbq[$];
    int   out_cyc[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lab3_logic_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .mode(mode), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .F_red(F_red), .beats(beats)
    );

    lab3_logic_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A), .B(B), .op(op), .mode(mode), .last(last),
        .out_valid(out_valid2), .out_ready(1'b1),
        .F(F2), .F_red(F_red2), .beats(beats2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("F", F, mon_e.f);
                check("F_red", F_red, |mon_e.f);
                check("beats", beats, mon_e.b);
            end
        end
    end

    task automatic beat(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic l, input bit push,
                        input logic [7:0] ef, input logic [3:0] eb);
        int n;
        op = o; A = a; B = b; mode = m; last = l; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        if (push) sbq.push_back('{ef, eb});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb, racc;
        logic [2:0] ro;
        int         n0, n;

        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; op = '0; mode = 1'b0; last = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_F", F, 8'h00);
        check("rst_F_red", F_red, 1'b0);
        check("rst_beats", beats, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        // PAIR AND, latency one
        beat(3'b000, 8'hF0, 8'h3C, 1'b0, 1'b0, 1, 8'h30, 4'd1);
        check("t1_latency", out_valid, 1'b1);
        @(posedge clk); #1;

        // back-to-back PAIR with no bubble
        out_cyc.delete();
        beat(3'b010, 8'hFF, 8'h0F, 1'b0, 1'b0, 1, 8'hF0, 4'd1);
        beat(3'b011, 8'hAA, 8'hFF, 1'b0, 1'b0, 1, 8'h55, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        if (out_cyc.size() >= 2) check("t2_nobubble", out_cyc[1] - out_cyc[0], 32'd1);
        else check("t2_count", out_cyc.size(), 32'd2);

        // ACCUM OR over three beats, exactly one result
        n0 = n_out;
        beat(3'b001, 8'h01, 8'h00, 1'b1, 1'b0, 0, 8'h00, 4'd0);
        beat(3'b001, 8'h02, 8'h00, 1'b1, 1'b0, 0, 8'h00, 4'd0);
        beat(3'b001, 8'h80, 8'h00, 1'b1, 1'b1, 1, 8'h83, 4'd3);
        repeat (3) @(posedge clk);
        #1 check("t3_once", n_out - n0, 32'd1);

        // single-beat XNOR burst
        beat(3'b101, 8'h0F, 8'h00, 1'b1, 1'b1, 1, 8'hF0, 4'd1);
        @(posedge clk); #1;

        // backpressure holds the result and stalls the next beat
        out_ready = 1'b0;
        beat(3'b000, 8'hFF, 8'h5A, 1'b0, 1'b0, 1, 8'h5A, 4'd1);
        op = 3'b001; A = 8'h11; B = 8'h22; mode = 1'b0; last = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t5_in_ready_low", in_ready, 1'b0);
            check("t5_F_held", F, 8'h5A);
            check("t5_out_valid_held", out_valid, 1'b1);
        end
        sbq.push_back('{8'h33, 4'd1});
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 check("t5_in_ready_high", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset mid-burst discards the partial burst
        beat(3'b000, 8'hF0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 4'd0);
        beat(3'b000, 8'h33, 8'h00, 1'b1, 1'b0, 0, 8'h00, 4'd0);
        #2 reset = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_F", F, 8'h00);
        check("t6_F_red", F_red, 1'b0);
        sbq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        beat(3'b000, 8'h0C, 8'h00, 1'b1, 1'b1, 1, 8'h0C, 4'd1);
        @(posedge clk); #1;

        // long NOR burst: beats saturates at 15, later op/mode ignored
        racc = 8'h00;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            racc = racc | ra;
            if (i == 0) beat(3'b100, ra, 8'h00, 1'b1, 1'b0, 0, 8'h00, 4'd0);
            else if (i < 19) beat(3'b000, ra, 8'hFF, 1'b0, 1'b0, 0, 8'h00, 4'd0);
            else beat(3'b010, ra, 8'hFF, 1'b0, 1'b1, 1, ~racc, 4'd15);
            if (i == 9) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end

        // random PAIR beats
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            beat(ro, ra, rb, 1'b0, 1'b0, 1, model(ro, ra, rb), 4'd1);
        end

        // narrow counter instance: five-beat burst saturates at 3
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            op = 3'b001; A = 8'(1 << i); B = 8'h00; mode = 1'b1; last = (i == 4); in_valid2 = 1'b1;
            @(negedge clk);
            check("cw2_in_ready", in_ready2, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b0;
        check("cw2_out_valid", out_valid2, 1'b1);
        check("cw2_F", F2, 8'h1F);
        check("cw2_F_red", F_red2, 1'b1);
        check("cw2_beats", beats2, 2'd3);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1 check("drain_pending", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
